// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM generator.
// Output polarity follows the PWM_ACTIVE_LOW_EN macro (defined: common-anode LED, active-low pins).
package rgb_pwm_pkg;

    localparam int unsigned PWM_W            = 8;
    localparam logic [PWM_W-1:0] PWM_CNT_MAX = 8'd254;
    localparam int unsigned PRESCALE_DEFAULT = 196;

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic PWM_INVERT = 1'b1;
`else
    localparam logic PWM_INVERT = 1'b0;
`endif

    // Pin level while in reset or disabled
    localparam logic PWM_IDLE = PWM_INVERT;

    // Map a logical "LED on" request to the physical pin level
    function automatic logic pwm_level(input logic active);
        return active ^ PWM_INVERT;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: period-aligned duty shadow, compare and registered pin.
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] shadow;

    // Duty shadow: only updated at a period boundary (or while disabled)
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= duty;
        end
    end

    // Registered compare; cnt never reaches 255 so duty 255 is a steady on
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= PWM_IDLE;
        end else begin
            pwm <= pwm_level(en && (cnt < shadow));
        end
    end

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel fixed-frequency PWM LED driver with glitch-free duty updates.
// Optional macro PWM_ACTIVE_LOW_EN inverts the pwm_r/g/b pin polarity.
module rgb_pwm_gen
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] R_time_in,
    input  logic [PWM_W-1:0] G_time_in,
    input  logic [PWM_W-1:0] B_time_in,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic             period_start
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] presc;
    logic [PWM_W-1:0]   cnt;
    logic               tick;
    logic               wrap;
    logic               load;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (cnt == PWM_CNT_MAX);
    // Shadows track inputs while disabled so the first enabled period uses current duty
    assign load = wrap || !en;

    // Prescaler and 255-step period counter; held cleared while disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc <= '0;
            cnt   <= '0;
        end else if (tick) begin
            presc <= '0;
            cnt   <= wrap ? '0 : cnt + PWM_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // One-clock strobe at each period wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= en && wrap;
        end
    end

    pwm_channel u_ch_r (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .cnt  (cnt),
        .duty (R_time_in),
        .pwm  (pwm_r)
    );

    pwm_channel u_ch_g (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .cnt  (cnt),
        .duty (G_time_in),
        .pwm  (pwm_g)
    );

    pwm_channel u_ch_b (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .cnt  (cnt),
        .duty (B_time_in),
        .pwm  (pwm_b)
    );

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen: one instance at PRESCALE=1, one at PRESCALE=4.
// Expected pin levels adapt to PWM_ACTIVE_LOW_EN.
module tb_rgb_pwm_gen;

`ifdef PWM_ACTIVE_LOW_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif
    localparam logic ACT = ~IDLE;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       p1_r, p1_g, p1_b, ps1;
    logic       p4_r, p4_g, p4_b, ps4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hi_r1, hi_g1, hi_b1, hi_b4, tog_r1;
    int ps1_n, ps4_n;
    int ps1_last = -1;
    int ps4_last = -1;
    int ps1_gap  = 0;
    int ps4_gap  = 0;
    logic prev_r1;

    rgb_pwm_gen #(.PRESCALE(1), .PRESC_W(8)) u1 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .R_time_in    (r_in),
        .G_time_in    (g_in),
        .B_time_in    (b_in),
        .pwm_r        (p1_r),
        .pwm_g        (p1_g),
        .pwm_b        (p1_b),
        .period_start (ps1)
    );

    rgb_pwm_gen #(.PRESCALE(4), .PRESC_W(8)) u4 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .R_time_in    (r_in),
        .G_time_in    (g_in),
        .B_time_in    (b_in),
        .pwm_r        (p4_r),
        .pwm_g        (p4_g),
        .pwm_b        (p4_b),
        .period_start (ps4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        hi_r1 = 0; hi_g1 = 0; hi_b1 = 0; hi_b4 = 0;
        tog_r1 = 0; ps1_n = 0; ps4_n = 0;
        prev_r1 = p1_r;
    endtask

    // Advance one clock, sample 1 time unit after the edge and accumulate statistics
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (p1_r === ACT) hi_r1++;
        if (p1_g === ACT) hi_g1++;
        if (p1_b === ACT) hi_b1++;
        if (p4_b === ACT) hi_b4++;
        if (p1_r !== prev_r1) tog_r1++;
        prev_r1 = p1_r;
        if (ps1 === 1'b1) begin
            ps1_n++;
            if (ps1_last >= 0) ps1_gap = cyc - ps1_last;
            ps1_last = cyc;
        end
        if (ps4 === 1'b1) begin
            ps4_n++;
            if (ps4_last >= 0) ps4_gap = cyc - ps4_last;
            ps4_last = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ps1(input int lim);
        int n = 0;
        do begin
            step();
            n++;
        end while (ps1 !== 1'b1 && n < lim);
        check("ps1_wait_timeout", 32'(ps1), 32'd1);
    endtask

    task automatic wait_ps4(input int lim);
        int n = 0;
        do begin
            step();
            n++;
        end while (ps4 !== 1'b1 && n < lim);
        check("ps4_wait_timeout", 32'(ps4), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        r_in = 8'($urandom);
        g_in = 8'($urandom);
        b_in = 8'($urandom);

        // Reset holds every output at its idle level
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_u1_pins", 32'({p1_r, p1_g, p1_b}), 32'({3{IDLE}}));
            check("rst_u1_ps",   32'(ps1), 32'd0);
            check("rst_u4_pins", 32'({p4_r, p4_g, p4_b}), 32'({3{IDLE}}));
            check("rst_u4_ps",   32'(ps4), 32'd0);
        end

        // Disabled: shadows follow inputs, pins idle
        rst  = 1'b0;
        en   = 1'b0;
        r_in = 8'd0;
        g_in = 8'd255;
        b_in = 8'd128;
        run(2);
        check("dis_u1_pins", 32'({p1_r, p1_g, p1_b, ps1}), 32'({IDLE, IDLE, IDLE, 1'b0}));

        // Enable: activity one clock later, then full-period duty counts
        en = 1'b1;
        clr();
        step();
        check("first_g_active", 32'(p1_g), 32'(ACT));
        check("first_b_active", 32'(p1_b), 32'(ACT));
        check("first_r_idle",   32'(p1_r), 32'(IDLE));
        run(254);
        check("p1_hi_r0",   32'(hi_r1), 32'd0);
        check("p1_hi_g255", 32'(hi_g1), 32'd255);
        check("p1_hi_b128", 32'(hi_b1), 32'd128);
        check("p1_ps_cnt",  32'(ps1_n), 32'd1);
        check("p1_ps_end",  32'(ps1),   32'd1);
        clr();
        run(255);
        check("p1_hi_g255_b", 32'(hi_g1),  32'd255);
        check("p1_hi_b128_b", 32'(hi_b1),  32'd128);
        check("p1_ps_gap",    32'(ps1_gap), 32'd255);

        // Mid-period duty change only affects the following period
        r_in = 8'd10;
        run(255);
        clr();
        run(50);
        r_in = 8'd200;
        run(205);
        check("midchg_hi_r10", 32'(hi_r1),  32'd10);
        check("midchg_tog",    32'(tog_r1), 32'd2);
        check("midchg_ps",     32'(ps1_n),  32'd1);
        clr();
        run(255);
        check("next_hi_r200", 32'(hi_r1),  32'd200);
        check("next_tog",     32'(tog_r1), 32'd2);

        // PRESCALE=4 instance: duty 64 -> 256 of 1020 cycles
        b_in = 8'd64;
        wait_ps4(1100);
        clr();
        run(1020);
        check("p4_hi_b256", 32'(hi_b4),   32'd256);
        check("p4_ps_cnt",  32'(ps4_n),   32'd1);
        check("p4_ps_gap",  32'(ps4_gap), 32'd1020);

        // Drop enable at cnt=100; pins idle and counter cleared on the next edge
        wait_ps1(300);
        run(100);
        en = 1'b0;
        clr();
        step();
        check("en0_u1", 32'({p1_r, p1_g, p1_b, ps1}), 32'({IDLE, IDLE, IDLE, 1'b0}));
        check("en0_u4", 32'({p4_r, p4_g, p4_b, ps4}), 32'({IDLE, IDLE, IDLE, 1'b0}));
        check("en0_cnt", 32'(u1.cnt), 32'd0);
        g_in = 8'd30;
        run(3);
        check("en0_hold_cnt", 32'(u1.cnt), 32'd0);
        check("en0_no_hi",    32'(hi_r1 + hi_g1 + hi_b1 + hi_b4), 32'd0);
        en = 1'b1;
        clr();
        run(255);
        check("en1_hi_g30",  32'(hi_g1), 32'd30);
        check("en1_ps1_cnt", 32'(ps1_n), 32'd1);
        check("en1_ps1_end", 32'(ps1),   32'd1);
        check("en1_ps4_cnt", 32'(ps4_n), 32'd0);

        // Reset mid-period clears everything including shadows
        run(40);
        rst = 1'b1;
        step();
        check("midrst_u1", 32'({p1_r, p1_g, p1_b, ps1}), 32'({IDLE, IDLE, IDLE, 1'b0}));
        check("midrst_cnt", 32'(u1.cnt), 32'd0);
        rst = 1'b0;
        clr();
        run(255);
        check("postrst_hi_g0", 32'(hi_g1), 32'd0);
        check("postrst_ps",    32'(ps1_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
